// File: rtl/sel_skid_mux_pkg.sv
// Shared definitions for the selector + 2-entry skid buffer.
// The {data, err} beat struct lives in the top, since its width follows WIDTH.
package sel_skid_mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/sel_skid_mux_pick.sv
// Combinational N-way pick. An out-of-range select yields zero data
// with the error flag raised.
module sel_skid_mux_pick #(
    parameter int N     = 5,
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]   i_sel,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_err
);

    always_comb begin
        o_data = '0;
        o_err  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_data[k*WIDTH +: WIDTH];
                o_err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sel_skid_mux.sv
// N-way selector feeding a registered 2-entry skid buffer, valid/ready on both sides.
// Main register drives the outputs; skid register absorbs one beat while out_ready is low.
module sel_skid_mux
    import sel_skid_mux_pkg::*;
#(
    parameter int N     = 5,
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_sel_err,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             err;
    } beat_t;

    state_e           r_state, w_next;
    beat_t            r_main, r_skid;
    logic             r_in_ready;
    logic [WIDTH-1:0] w_pick_data;
    logic             w_pick_err;
    logic             w_accept, w_pop, w_out_valid;
    logic             w_load_main_in, w_load_main_skid, w_load_skid, w_clr_main;

    sel_skid_mux_pick #(.N(N), .WIDTH(WIDTH), .SEL_W(SEL_W)) u_pick (
        .i_data (in_data),
        .i_sel  (sel),
        .o_data (w_pick_data),
        .o_err  (w_pick_err)
    );

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = in_valid & r_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    // State register; in_ready is registered from the next state so it has no comb path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != ST_TWO);
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) w_next = ST_ONE;
                ST_ONE: begin
                    if (w_accept && !w_pop)      w_next = ST_TWO;
                    else if (!w_accept && w_pop) w_next = ST_EMPTY;
                end
                ST_TWO:   if (w_pop) w_next = ST_ONE;
                default:  w_next = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_clr_main       = 1'b0;
        if (flush) begin
            w_clr_main = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: w_load_main_in = w_accept;
                ST_ONE: begin
                    if (w_accept && w_pop) w_load_main_in = 1'b1;
                    else if (w_accept)     w_load_skid    = 1'b1;
                    else if (w_pop)        w_clr_main     = 1'b1;
                end
                ST_TWO:   w_load_main_skid = w_pop;
                default:  w_clr_main = 1'b1;
            endcase
        end
    end

    // Main is zeroed whenever the buffer drains so outputs read 0 while invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_clr_main)
                r_main <= '0;
            else if (w_load_main_in)
                r_main <= '{data: w_pick_data, err: w_pick_err};
            else if (w_load_main_skid)
                r_main <= r_skid;

            if (w_load_skid)
                r_skid <= '{data: w_pick_data, err: w_pick_err};
            else if (w_load_main_skid || flush)
                r_skid <= '0;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = w_out_valid;
    assign out_data    = r_main.data;
    assign out_sel_err = r_main.err;

endmodule
